// File: rtl/wb_multi_counter.sv
// Wishbone classic slave with NCH up/down counters, compare match, auto-reload and W1C status irq.
// Latency: ack one cycle after a request, never back-to-back; optional shared prescaler (WB_COUNTER_PRESCALE_EN).
// Backpressure: none; every request is acked, writes to unmapped slots are dropped.
module wb_multi_counter #(
    parameter int BITS = 32,
    parameter int NCH  = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [NCH*BITS-1:0] count_o,
    output logic [NCH-1:0]      match_o,
    output logic                irq_o
);
    localparam logic [4:0]      ADR_PRESCALE = 5'b11110;
    localparam logic [4:0]      ADR_STATUS   = 5'b11111;
    localparam logic [BITS-1:0] ONE          = BITS'(1);

    logic [BITS-1:0] count_q  [NCH];
    logic [BITS-1:0] count_d  [NCH];
    logic [BITS-1:0] cmp_q    [NCH];
    logic [BITS-1:0] cmp_d    [NCH];
    logic [3:0]      ctrl_q   [NCH];
    logic [3:0]      ctrl_d   [NCH];
    logic [BITS-1:0] step_val [NCH];
    logic [NCH-1:0]  wr_hit;
    logic [NCH-1:0]  ie_vec;
    logic [NCH-1:0]  st_clr;
    logic [NCH-1:0]  status_q, status_d;
    logic [NCH-1:0]  match_q, match_d;
    logic            irq_q, irq_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;
    logic [31:0]     rdata;
    logic            req, wr, special, ch_ok, tick;
    logic [4:0]      radr;
    logic [2:0]      ch;
    logic [1:0]      rsel;
    logic            unused_adr;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    assign radr       = wbs_adr_i[6:2];
    assign ch         = wbs_adr_i[6:4];
    assign rsel       = wbs_adr_i[3:2];
    assign unused_adr = ^{wbs_adr_i[31:7], wbs_adr_i[1:0]};

    assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr  = req & wbs_we_i;
    // STATUS/PRESCALE take priority over the channel-7 slots they alias.
    assign special = (radr == ADR_STATUS) || (radr == ADR_PRESCALE);
    assign ch_ok   = !special && (int'(ch) < NCH);

`ifdef WB_COUNTER_PRESCALE_EN
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] div_q, div_d;

    assign tick = (div_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        div_d      = tick ? 16'd0 : div_q + 16'd1;
        if (wr && radr == ADR_PRESCALE) begin
            prescale_d = 16'(byte_merge({16'd0, prescale_q}, wbs_dat_i, wbs_sel_i));
            div_d      = 16'd0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            prescale_q <= '0;
            div_q      <= '0;
        end else begin
            prescale_q <= prescale_d;
            div_q      <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            step_val[n] = ctrl_q[n][1] ? count_q[n] - ONE : count_q[n] + ONE;
            wr_hit[n]   = wr && ch_ok && (ch == 3'(n));
            ie_vec[n]   = ctrl_q[n][3];
            count_d[n]  = count_q[n];
            cmp_d[n]    = cmp_q[n];
            ctrl_d[n]   = ctrl_q[n];
            match_d[n]  = 1'b0;
            if (ctrl_q[n][0] && tick) begin
                count_d[n] = step_val[n];
                if (step_val[n] == cmp_q[n]) begin
                    match_d[n] = 1'b1;
                    if (ctrl_q[n][2]) begin
                        count_d[n] = ctrl_q[n][1] ? cmp_q[n] : '0;
                    end
                end
            end
            // A COUNT write overrides the step and suppresses that cycle's match.
            if (wr_hit[n]) begin
                case (rsel)
                    2'd0: ctrl_d[n] = 4'(byte_merge(32'(ctrl_q[n]), wbs_dat_i, wbs_sel_i));
                    2'd1: begin
                        count_d[n] = BITS'(byte_merge(32'(count_q[n]), wbs_dat_i, wbs_sel_i));
                        match_d[n] = 1'b0;
                    end
                    2'd2: cmp_d[n] = BITS'(byte_merge(32'(cmp_q[n]), wbs_dat_i, wbs_sel_i));
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        st_clr = '0;
        if (wr && radr == ADR_STATUS && wbs_sel_i[0]) begin
            st_clr = wbs_dat_i[NCH-1:0];
        end
        status_d = (status_q & ~st_clr) | match_d;
        irq_d    = |(status_q & ie_vec);

        rdata = '0;
        if (radr == ADR_STATUS) begin
            rdata = 32'(status_q);
`ifdef WB_COUNTER_PRESCALE_EN
        end else if (radr == ADR_PRESCALE) begin
            rdata = 32'(prescale_q);
`endif
        end else if (ch_ok) begin
            for (int n = 0; n < NCH; n++) begin
                if (ch == 3'(n)) begin
                    case (rsel)
                        2'd0:    rdata = 32'(ctrl_q[n]);
                        2'd1:    rdata = 32'(count_q[n]);
                        2'd2:    rdata = 32'(cmp_q[n]);
                        default: rdata = '0;
                    endcase
                end
            end
        end

        ack_d = req;
        dat_d = (req && !wbs_we_i) ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int n = 0; n < NCH; n++) begin
                count_q[n] <= '0;
                cmp_q[n]   <= '0;
                ctrl_q[n]  <= '0;
            end
            status_q <= '0;
            match_q  <= '0;
            irq_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                count_q[n] <= count_d[n];
                cmp_q[n]   <= cmp_d[n];
                ctrl_q[n]  <= ctrl_d[n];
            end
            status_q <= status_d;
            match_q  <= match_d;
            irq_q    <= irq_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            count_o[n*BITS +: BITS] = count_q[n];
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign match_o   = match_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_wb_multi_counter.sv
// Bench for wb_multi_counter (BITS=8, NCH=4): directed register scenarios plus random bus traffic vs. a reference model.
`timescale 1ns/1ps
module tb_wb_multi_counter;
    localparam int BITS = 8;
    localparam int NCH  = 4;
    localparam int unsigned MOD  = 1 << BITS;
    localparam int unsigned CMSK = MOD - 1;
`ifdef WB_COUNTER_PRESCALE_EN
    localparam bit PS_EN = 1'b1;
`else
    localparam bit PS_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cyc, stb, we;
    logic [3:0]          sel;
    logic [31:0]         adr, wdat;
    logic                ack;
    logic [31:0]         rdat;
    logic [NCH*BITS-1:0] count;
    logic [NCH-1:0]      match;
    logic                irq;

    always #5 clk = ~clk;

    wb_multi_counter #(.BITS(BITS), .NCH(NCH)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .count_o  (count),
        .match_o  (match),
        .irq_o    (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int unsigned    m_count [NCH];
    int unsigned    m_cmp   [NCH];
    int unsigned    m_ctrl  [NCH];
    int unsigned    m_status, m_prescale, m_div;
    bit             exp_ack, exp_rd, exp_irq;
    logic [31:0]    exp_dat;
    logic [NCH-1:0] exp_match;

    function automatic int unsigned merge_bytes(input int unsigned old_val, input logic [31:0] d,
                                                input logic [3:0] s, input int unsigned mask);
        int unsigned r = old_val;
        for (int b = 0; b < 4; b++)
            if (s[b]) r = (r & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
        return r & mask;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_count[n] = 0; m_cmp[n] = 0; m_ctrl[n] = 0;
        end
        m_status = 0; m_prescale = 0; m_div = 0;
        exp_ack = 0; exp_rd = 0; exp_irq = 0; exp_dat = '0; exp_match = '0;
    endfunction

    function automatic void model_clock();
        bit req, tick, special, wrote;
        int a, c, r;
        int unsigned rd, clr, nxt;
        req     = cyc && stb && !exp_ack;
        a       = int'(adr[6:2]);
        c       = int'(adr[6:4]);
        r       = int'(adr[3:2]);
        special = (a >= 30);
        rd = 0;
        if (a == 31)      rd = m_status;
        else if (a == 30) rd = PS_EN ? m_prescale : 0;
        else if (c < NCH) rd = (r == 0) ? m_ctrl[c] : (r == 1) ? m_count[c] : (r == 2) ? m_cmp[c] : 0;
        exp_irq = 1'b0;
        for (int n = 0; n < NCH; n++)
            if (m_status[n] && m_ctrl[n][3]) exp_irq = 1'b1;
        tick = PS_EN ? (m_div == m_prescale) : 1'b1;
        for (int n = 0; n < NCH; n++) begin
            wrote = req && we && !special && (c == n) && (r == 1);
            exp_match[n] = 1'b0;
            if (m_ctrl[n][0] && tick && !wrote) begin
                nxt = m_ctrl[n][1] ? (m_count[n] + MOD - 1) % MOD : (m_count[n] + 1) % MOD;
                if (nxt == m_cmp[n]) begin
                    exp_match[n] = 1'b1;
                    if (m_ctrl[n][2]) nxt = m_ctrl[n][1] ? m_cmp[n] : 0;
                end
                m_count[n] = nxt;
            end
        end
        if (req && we && !special && c < NCH) begin
            case (r)
                0: m_ctrl[c]  = merge_bytes(m_ctrl[c], wdat, sel, 15);
                1: m_count[c] = merge_bytes(m_count[c], wdat, sel, CMSK);
                2: m_cmp[c]   = merge_bytes(m_cmp[c], wdat, sel, CMSK);
                default: ;
            endcase
        end
        clr = (req && we && a == 31 && sel[0]) ? (wdat & ((1 << NCH) - 1)) : 0;
        m_status = (m_status & ~clr) | 32'(exp_match);
        if (PS_EN) begin
            if (req && we && a == 30) begin
                m_prescale = merge_bytes(m_prescale, wdat, sel, 32'hFFFF);
                m_div      = 0;
            end else begin
                m_div = tick ? 0 : m_div + 1;
            end
        end
        exp_ack = req;
        exp_rd  = req && !we;
        exp_dat = rd;
    endfunction

    function automatic logic [NCH*BITS-1:0] pack_counts();
        logic [NCH*BITS-1:0] p;
        for (int n = 0; n < NCH; n++) p[n*BITS +: BITS] = BITS'(m_count[n]);
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_clock();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", 32'(ack), 32'(exp_ack));
            if (exp_ack && exp_rd) check("rdata", rdat, exp_dat);
            check("match", 32'(match), 32'(exp_match));
            check("irq", 32'(irq), 32'(exp_irq));
            check("count", 32'(count), 32'(pack_counts()));
        end
    end

    // ---------------- bus helpers ----------------
    task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        int lat = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 8);
        check("ack_latency", 32'(lat), 32'd1);
        rd  = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, s, dummy);
    endtask

    task automatic wb_rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_xfer(1'b0, a, 32'h0, 4'hF, v);
        check(name, v, exp);
    endtask

    task automatic wait_match(input int n);
        int k = 0;
        while (!match[n] && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("match_wait", 32'(match[n]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c0, c1;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // ch0 counts 1,2,3 after enable; COUNT read returns pre-step value
        wb_wr(32'h00, 32'h1, 4'hF);
        check("ch0_at_ack", 32'(count[7:0]), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("ch0_step", 32'(count[7:0]), 32'(k));
        end
        wb_rd_check("ch0_count_read", 32'h04, 32'd4);
        wb_wr(32'h00, 32'h0, 4'hF);

        // ch1 down-count with auto-reload at CMP=0xFD
        wb_wr(32'h14, 32'h0, 4'hF);
        wb_wr(32'h18, 32'hFD, 4'hF);
        wb_wr(32'h10, 32'h7, 4'hF);
        wait_match(1);
        check("ch1_at_match", 32'(count[15:8]), 32'hFD);
        @(negedge clk);
        check("ch1_after", 32'(count[15:8]), 32'hFC);
        check("ch1_no_irq", 32'(irq), 32'd0);
        wb_wr(32'h10, 32'h0, 4'hF);
        wb_wr(32'h7C, 32'h2, 4'h1);

        // ch2 up-count to 5 with reload and irq; W1C and set-beats-clear
        wb_wr(32'h28, 32'h5, 4'hF);
        wb_wr(32'h20, 32'hD, 4'hF);
        wait_match(2);
        check("ch2_reload", 32'(count[23:16]), 32'd0);
        check("ch2_irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check("ch2_irq", 32'(irq), 32'd1);
        wb_wr(32'h7C, 32'h4, 4'h1);
        @(negedge clk);
        check("ch2_irq_clr", 32'(irq), 32'd0);
        wait_match(2);
        repeat (3) @(negedge clk);
        wb_wr(32'h7C, 32'h4, 4'h1);
        check("concur_match", 32'(match[2]), 32'd1);
        wb_rd_check("concur_status", 32'h7C, 32'h4);
        wb_wr(32'h20, 32'h0, 4'hF);
        wb_wr(32'h7C, 32'hF, 4'h1);

        // byte enables, width truncation, CTRL reserved bits, write beats step
        wb_wr(32'h34, 32'h1234, 4'b0001);
        wb_rd_check("ch3_lowbyte", 32'h34, 32'h34);
        wb_wr(32'h34, 32'hFFFF_5600, 4'b1110);
        wb_rd_check("ch3_upper_ign", 32'h34, 32'h34);
        wb_wr(32'h30, 32'h1F1, 4'b0011);
        wb_rd_check("ch3_ctrl", 32'h30, 32'h1);
        wb_wr(32'h34, 32'h80, 4'hF);
        check("ch3_write_wins", 32'(count[31:24]), 32'h80);
        @(negedge clk);
        check("ch3_resume", 32'(count[31:24]), 32'h81);

        // unmapped channels / slots
        wb_wr(32'h44, 32'h55, 4'hF);
        wb_rd_check("ch4_count", 32'h44, 32'h0);
        wb_rd_check("ch5_pad", 32'h5C, 32'h0);
        wb_rd_check("ch0_pad", 32'h0C, 32'h0);

        // prescaler
        wb_wr(32'h78, 32'h3, 4'hF);
        wb_rd_check("prescale_rd", 32'h78, PS_EN ? 32'h3 : 32'h0);
        @(negedge clk);
        c0 = count[31:24];
        repeat (8) @(negedge clk);
        c1 = count[31:24];
        check("prescale_rate", 32'(8'(c1 - c0)), PS_EN ? 32'd2 : 32'd8);
        wb_wr(32'h78, 32'h0, 4'hF);

        // reset between stb and ack
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h34; sel = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_dat", rdat, 32'd0);
        check("arst_irq_match", {31'd0, irq} | 32'(match), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("ack_in_reset", 32'(ack), 32'd0);
        end
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        wb_rd_check("post_rst_count", 32'h34, 32'h0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] a5;
            @(negedge clk);
            cyc = ($urandom_range(0, 3) != 0);
            stb = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) a5 = {3'($urandom_range(0, NCH-1)), 2'($urandom_range(0, 3))};
            else                           a5 = 5'($urandom_range(0, 31));
            adr  = {25'($urandom), a5, 2'($urandom)};
            wdat = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (a5 == 5'b11110) wdat = 32'($urandom_range(0, 3));
            sel  = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_multi_counter.md
WB_MULTI_COUNTER -- requirements
Module: wb_multi_counter

Interface
REQ-001 Parameter BITS, default 32, counter width per channel; legal range 8..32.
REQ-002 Parameter NCH, default 4, number of independent counter channels; legal range 1..8.
REQ-003 wb_clk_i  input  1  single clock for all logic.
REQ-004 wb_rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave controls.
REQ-006 wbs_sel_i  input  4  byte enables.
REQ-007 wbs_adr_i  input  32  byte address; only bits [6:2] decoded.
REQ-008 wbs_dat_i  input  32  write data.
REQ-009 wbs_ack_o  output  1  single-cycle acknowledge.
REQ-010 wbs_dat_o  output  32  read data, valid while wbs_ack_o=1.
REQ-011 count_o  output  NCH*BITS  live counts, channel n at [n*BITS +: BITS].
REQ-012 match_o  output  NCH  one-cycle pulse per channel on compare match.
REQ-013 irq_o  output  1  level interrupt, OR of enabled pending status bits.

Function
REQ-014 Access valid = cyc & stb; ack SHALL assert the cycle after valid rises and SHALL NOT assert on the cycle following an ack (no back-to-back acks).
REQ-015 Register map: adr[6:4] = channel, adr[3:2] = 0 CTRL, 1 COUNT, 2 CMP; adr[6:2]=5'b11111 = STATUS; channel index >= NCH reads 0, writes ignored, still acked.
REQ-016 CTRL bits: [0] EN, [1] DOWN, [2] AUTORELOAD, [3] IE; other bits read 0.
REQ-017 Writes SHALL honour wbs_sel_i per byte; bits above BITS ignored; reads zero-extended to 32 bits.
REQ-018 Each enabled channel SHALL step once per tick: +1 when DOWN=0, -1 when DOWN=1, modulo 2^BITS (wrap all-ones->0 up, 0->all-ones down).
REQ-019 Match when EN=1, tick, and post-step count == CMP: match_o[n] pulses one cycle, STATUS[n] sets.
REQ-020 On match with AUTORELOAD=1 the next stored count SHALL be 0 (up) or CMP (down) instead of the stepped value; with AUTORELOAD=0 counting continues.
REQ-021 Write to COUNT in the same cycle as a step SHALL win; no match evaluated for that channel that cycle.
REQ-022 STATUS is write-1-to-clear; a set and a clear of the same bit in one cycle SHALL leave it set.
REQ-023 irq_o = OR over n of (STATUS[n] & IE[n]), registered, one cycle after status change.
REQ-024 Read data SHALL reflect register contents at the cycle of the request; COUNT read captured before that cycle's step.

Reset
REQ-025 On wb_rst_ni=0, immediately: all COUNT, CMP, CTRL, STATUS = 0; wbs_ack_o=0; wbs_dat_o=0; match_o=0; irq_o=0; prescaler = 0.
REQ-026 Reset mid-transaction SHALL drop the pending ack; the master re-issues after release.
REQ-027 Deassertion is used directly; no registers update until the first wb_clk_i edge after release.

Configuration
REQ-028 Macro WB_COUNTER_PRESCALE_EN defined: adr[6:2]=5'b11110 is a 16-bit PRESCALE register (reset 0) shared by all channels; tick asserts once every PRESCALE+1 clocks via a free-running divider, divider cleared on PRESCALE write.
REQ-029 Macro undefined: tick = 1 every clock; address 5'b11110 reads 0, writes ignored, acked.

Verification
REQ-030 Reset, write CTRL ch0=0x1 -> COUNT ch0 reads 1,2,3... per clock after EN write ack; ack exactly one cycle after stb each access.
REQ-031 BITS=8, ch1 CTRL=0x3 (EN,DOWN), COUNT=0 -> next step 0xFF; CMP=0xFD, AUTORELOAD -> match_o[1] pulse at 0xFD, next count 0xFD.
REQ-032 ch2 CMP=5, CTRL=0xD (EN,AUTORELOAD,IE) from 0 -> match at 5, count 0, irq_o=1 next cycle; write STATUS=0x4 -> irq_o=0; concurrent match+clear -> stays set.
REQ-033 Write COUNT=0x1234 with sel=4'b0001 -> only low byte updated; write in a step cycle -> value stored exactly, not incremented.
REQ-034 With WB_COUNTER_PRESCALE_EN, PRESCALE=3, EN ch0 -> count increments every 4 clocks; without macro, PRESCALE reads 0 and count steps every clock.
REQ-035 Assert wb_rst_ni low between stb and ack -> no ack, all outputs 0 asynchronously, next access completes normally.
